// File: rtl/my_univ_shreg.sv
// my_univ_shreg: WIDTH-bit universal register (hold / shift right /
// shift left / parallel load) with synchronous set, asynchronous clear
// and a multi-step shift/rotate engine that runs AMT steps, one per clock.
//
// Launch/complete protocol: START is sampled only while the engine is idle
// (dbg_state_o == IDLE) and only acts when MODE is 01 or 10. It is a
// request that is always accepted on the edge where it is seen. BUSY is
// high while further steps remain after the launch edge. DONE is a single
// registered pulse in the cycle after the final step (or after the launch
// edge when AMT is 0 or 1). SET or CLRn abort a run with no DONE.
module my_univ_shreg #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             CLK,
   input  logic             CLRn,
   input  logic             SET,
   input  logic [1:0]       MODE,
   input  logic             ROT,
   input  logic             SIN_R,
   input  logic             SIN_L,
   input  logic [WIDTH-1:0] D,
   input  logic             START,
   input  logic [AMT_W-1:0] AMT,
   output logic [WIDTH-1:0] Q,
   output logic             BUSY,
   output logic             DONE,
   output logic             dbg_state_o
);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   logic [WIDTH-1:0] q_q, q_d;
   logic             state_q, state_d;
   logic             left_q, left_d;
   logic             rot_q, rot_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // One shift step; serial inputs are taken live from the ports.
   function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] v,
                                                input logic left,
                                                input logic rot,
                                                input logic sin_r,
                                                input logic sin_l);
      logic fill;
      if (left) begin
         fill = rot ? v[WIDTH-1] : sin_l;
         return {v[WIDTH-2:0], fill};
      end else begin
         fill = rot ? v[0] : sin_r;
         return {fill, v[WIDTH-1:1]};
      end
   endfunction

   // Next-state logic: SET beats an active run, which beats MODE.
   always_comb begin
      q_d     = q_q;
      state_d = state_q;
      left_d  = left_q;
      rot_d   = rot_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (SET) begin
         q_d     = {WIDTH{1'b1}};
         state_d = ST_IDLE;
         busy_d  = 1'b0;
         cnt_d   = '0;
      end else if (state_q == ST_SHIFT) begin
         q_d = step_fn(q_q, left_q, rot_q, SIN_R, SIN_L);
         if (cnt_q == AMT_W'(1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q - AMT_W'(1);
         end
      end else if (START && (MODE == MODE_RIGHT || MODE == MODE_LEFT)) begin
         left_d = (MODE == MODE_LEFT);
         rot_d  = ROT;
         if (AMT != '0) begin
            q_d = step_fn(q_q, MODE == MODE_LEFT, ROT, SIN_R, SIN_L);
         end
         if (AMT <= AMT_W'(1)) begin
            done_d = 1'b1;
         end else begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
            cnt_d   = AMT - AMT_W'(1);
         end
      end else begin
         case (MODE)
            MODE_RIGHT: q_d = step_fn(q_q, 1'b0, ROT, SIN_R, SIN_L);
            MODE_LEFT:  q_d = step_fn(q_q, 1'b1, ROT, SIN_R, SIN_L);
            MODE_LOAD:  q_d = D;
            MODE_HOLD:  q_d = q_q;
            default:    q_d = q_q;
         endcase
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge CLK or negedge CLRn) begin
      if (!CLRn) begin
         q_q     <= '0;
         state_q <= ST_IDLE;
         left_q  <= 1'b0;
         rot_q   <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         q_q     <= q_d;
         state_q <= state_d;
         left_q  <= left_d;
         rot_q   <= rot_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Q           = q_q;
   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_my_univ_shreg.sv
// Bench for my_univ_shreg: directed walk through the test plan followed by
// a randomized phase, all compared against a cycle-indexed reference model.
module tb_my_univ_shreg;

   localparam int W  = 8;
   localparam int AW = 3;

   logic          CLK = 1'b0;
   logic          CLRn;
   logic          SET;
   logic [1:0]    MODE;
   logic          ROT;
   logic          SIN_R;
   logic          SIN_L;
   logic [W-1:0]  D;
   logic          START;
   logic [AW-1:0] AMT;
   logic [W-1:0]  Q;
   logic          BUSY;
   logic          DONE;
   logic          dbg_state;

   int tests = 0;
   int fails = 0;

   // ---- clock ----
   always #5 CLK = ~CLK;

   my_univ_shreg #(.WIDTH(W), .AMT_W(AW)) dut (
      .CLK(CLK), .CLRn(CLRn), .SET(SET), .MODE(MODE), .ROT(ROT),
      .SIN_R(SIN_R), .SIN_L(SIN_L), .D(D), .START(START), .AMT(AMT),
      .Q(Q), .BUSY(BUSY), .DONE(DONE), .dbg_state_o(dbg_state)
   );

   // ---- reference model: a run is "active" until edge number m_end ----
   logic [W-1:0] m_q = '0;
   logic         m_active = 1'b0;
   logic         m_done = 1'b0;
   logic         m_left = 1'b0;
   logic         m_rot = 1'b0;
   int           m_end = 0;
   int           cyc = 0;

   function automatic logic [W-1:0] mstep(input logic [W-1:0] v, input logic left,
                                          input logic rot, input logic sr, input logic sl);
      logic [W-1:0] fill;
      if (left) begin
         fill = W'(rot ? v[W-1] : sl);
         return (v << 1) | fill;
      end
      fill = W'(rot ? v[0] : sr);
      return (v >> 1) | (fill << (W - 1));
   endfunction

   task automatic model_edge();
      logic done_n;
      done_n = 1'b0;
      if (SET) begin
         m_q = '1;
         m_active = 1'b0;
      end else if (m_active) begin
         m_q = mstep(m_q, m_left, m_rot, SIN_R, SIN_L);
         if (cyc == m_end) begin
            m_active = 1'b0;
            done_n = 1'b1;
         end
      end else if (START && (MODE == 2'd1 || MODE == 2'd2)) begin
         m_left = (MODE == 2'd2);
         m_rot  = ROT;
         if (int'(AMT) > 0) m_q = mstep(m_q, m_left, m_rot, SIN_R, SIN_L);
         if (int'(AMT) <= 1) done_n = 1'b1;
         else begin
            m_active = 1'b1;
            m_end = cyc + int'(AMT) - 1;
         end
      end else begin
         if (MODE == 2'd1) m_q = mstep(m_q, 1'b0, ROT, SIN_R, SIN_L);
         else if (MODE == 2'd2) m_q = mstep(m_q, 1'b1, ROT, SIN_R, SIN_L);
         else if (MODE == 2'd3) m_q = D;
      end
      m_done = done_n;
      cyc++;
   endtask

   task automatic model_clear();
      m_q = '0;
      m_active = 1'b0;
      m_done = 1'b0;
   endtask

   // ---- scoreboard helpers ----
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".q"}, 32'(Q), 32'(m_q));
      chk({tag, ".busy"}, 32'(BUSY), 32'(m_active));
      chk({tag, ".done"}, 32'(DONE), 32'(m_done));
      chk({tag, ".state"}, 32'(dbg_state), 32'(m_active));
   endtask

   // ---- driver tasks: inputs change at posedge+1 only ----
   task automatic tick(input string tag);
      model_edge();
      @(posedge CLK);
      #1;
      chk_model(tag);
   endtask

   task automatic idle_inputs();
      SET = 0; MODE = 2'd0; ROT = 0; SIN_R = 0; SIN_L = 0;
      START = 0; AMT = '0;
   endtask

   task automatic load(input logic [W-1:0] v);
      idle_inputs();
      MODE = 2'd3; D = v;
      tick("load");
      MODE = 2'd0;
   endtask

   task automatic async_clear(input string tag);
      #2 CLRn = 0;
      #1;
      model_clear();
      chk({tag, ".q"}, 32'(Q), 32'h0);
      chk({tag, ".busy"}, 32'(BUSY), 32'h0);
      chk({tag, ".done"}, 32'(DONE), 32'h0);
      CLRn = 1;
   endtask

   initial begin
      // ---- reset ----
      idle_inputs();
      D = '0;
      CLRn = 0;
      #3;
      chk("rst.q", 32'(Q), 32'h0);
      chk("rst.busy", 32'(BUSY), 32'h0);
      chk("rst.done", 32'(DONE), 32'h0);
      CLRn = 1;
      @(posedge CLK); #1;

      // ---- async clear between edges ----
      load(8'h5A);
      chk("ld5a", 32'(Q), 32'h5A);
      async_clear("clr");
      MODE = 2'd3; D = 8'hA5;
      tick("ldA5");
      chk("ldA5.k", 32'(Q), 32'hA5);
      MODE = 2'd0;
      tick("hold");
      chk("hold.k", 32'(Q), 32'hA5);

      // ---- single steps ----
      load(8'h81);
      MODE = 2'd1; ROT = 0; SIN_R = 0;
      tick("sr");
      chk("sr.k", 32'(Q), 32'h40);
      load(8'h81);
      MODE = 2'd2; SIN_L = 1;
      tick("sl");
      chk("sl.k", 32'(Q), 32'h03);
      load(8'h81);
      MODE = 2'd1; ROT = 1;
      tick("rr");
      chk("rr.k", 32'(Q), 32'hC0);

      // ---- multi-step rotate, MODE churn ignored ----
      load(8'h01);
      START = 1; MODE = 2'd1; ROT = 1; AMT = 3'd3;
      tick("mr1");
      chk("mr1.k", 32'(Q), 32'h80);
      chk("mr1.b", 32'(BUSY), 32'h1);
      START = 0; MODE = 2'd3; D = 8'hFF; ROT = 0;
      tick("mr2");
      chk("mr2.k", 32'(Q), 32'h40);
      MODE = 2'd2;
      tick("mr3");
      chk("mr3.k", 32'(Q), 32'h20);
      chk("mr3.d", 32'(DONE), 32'h1);
      chk("mr3.b", 32'(BUSY), 32'h0);
      MODE = 2'd0;
      tick("mr4");
      chk("mr4.d", 32'(DONE), 32'h0);

      // ---- boundaries ----
      START = 1; MODE = 2'd1; AMT = 3'd0;
      tick("amt0");
      chk("amt0.q", 32'(Q), 32'h20);
      chk("amt0.d", 32'(DONE), 32'h1);
      MODE = 2'd3; D = 8'h3C; AMT = 3'd4;
      tick("stld");
      chk("stld.q", 32'(Q), 32'h3C);
      chk("stld.d", 32'(DONE), 32'h0);
      load(8'hFF);
      START = 1; MODE = 2'd2; ROT = 0; SIN_L = 0; AMT = 3'd7;
      tick("a7.0");
      START = 0;
      for (int i = 1; i < 7; i++) tick("a7");
      chk("a7.q", 32'(Q), 32'h80);
      chk("a7.d", 32'(DONE), 32'h1);

      // ---- SET abort ----
      load(8'h10);
      START = 1; MODE = 2'd1; ROT = 0; SIN_R = 0; AMT = 3'd5;
      tick("ab1");
      START = 0; SET = 1;
      tick("ab2");
      chk("ab2.q", 32'(Q), 32'hFF);
      chk("ab2.b", 32'(BUSY), 32'h0);
      SET = 0; MODE = 2'd0;
      tick("ab3");
      chk("ab3.d", 32'(DONE), 32'h0);
      START = 1; MODE = 2'd1; AMT = 3'd1; SIN_R = 0;
      tick("ab4");
      chk("ab4.q", 32'(Q), 32'h7F);
      chk("ab4.d", 32'(DONE), 32'h1);

      // ---- clear mid-run ----
      load(8'h3C);
      START = 1; MODE = 2'd1; ROT = 1; AMT = 3'd6;
      tick("cm1");
      START = 0;
      tick("cm2");
      async_clear("cmclr");
      load(8'h03);
      START = 1; MODE = 2'd2; ROT = 0; SIN_L = 1; AMT = 3'd2;
      tick("cm3");
      START = 0;
      tick("cm4");
      chk("cm4.q", 32'(Q), 32'h0F);
      chk("cm4.d", 32'(DONE), 32'h1);

      // ---- randomized phase ----
      for (int i = 0; i < 400; i++) begin
         SET   = ($urandom_range(0, 19) == 0);
         MODE  = 2'($urandom_range(0, 3));
         ROT   = 1'($urandom_range(0, 1));
         SIN_R = 1'($urandom_range(0, 1));
         SIN_L = 1'($urandom_range(0, 1));
         D     = W'($urandom);
         START = ($urandom_range(0, 3) == 0);
         AMT   = AW'($urandom);
         tick("rnd");
         if ($urandom_range(0, 39) == 0) async_clear("rndclr");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
